// File: rtl/ru_ram_pkg.sv
// Shared types and defaults for the word-organised data RAM.
// Imported by the storage array and the access controller.
package ru_ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 32;
    localparam int DEPTH_DEF   = 256;
    localparam int LATENCY_DEF = 2;

    // Number of byte-address bits that select a byte within one word.
    function automatic int off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/ru_ram_array.sv
// DEPTH x DATA_W word storage.
// Synchronous byte-lane write, combinational read; contents never reset.
module ru_ram_array
    import ru_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [DATA_W/8-1:0]      be,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/ru_ram_ws.sv
// Data RAM with configurable wait states, byte-enable writes and
// a busy/done handshake toward the core's load/store path.
module ru_ram_ws
    import ru_ram_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic                read_enable,
    input  logic                write_enable,
    output logic [DATA_W-1:0]   data_out,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int BE_W   = DATA_W / 8;
    localparam int OFF_W  = off_w(DATA_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int SPAN_W = OFF_W + IDX_W;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [ADDR_W-1:0] ALIGN_M = ADDR_W'(BE_W - 1);
    localparam logic [CNT_W-1:0]  CNT_INI = CNT_W'(LATENCY - 1);

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  a_q;
    logic [DATA_W-1:0]  d_q;
    logic [BE_W-1:0]    be_q;
    logic               wr_q;
    logic               req;
    logic               bad;
    logic               fire;
    logic               mem_we;
    logic [IDX_W-1:0]   idx;
    logic [DATA_W-1:0]  rdata;

    assign req  = read_enable | write_enable;
    assign idx  = a_q[OFF_W +: IDX_W];
    // Misaligned, or any address bit above the storage span is set.
    assign bad  = ((a_q & ALIGN_M) != '0) || ((a_q >> SPAN_W) != '0);
    assign fire = (state == WAIT) && (cnt == '0);
    assign mem_we = fire && wr_q && !bad && nRst;

    ru_ram_array #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .be   (be_q),
        .idx  (idx),
        .wdata(d_q),
        .rdata(rdata)
    );

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                busy = req;
                if (req) state_n = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (cnt == '0) state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state    <= IDLE;
            cnt      <= '0;
            data_out <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (req) cnt <= CNT_INI;
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        err <= bad;
                        if (!wr_q) data_out <= bad ? '0 : rdata;
                    end
                end
                DONE: err <= 1'b0;
                default: ;
            endcase
        end
    end

    // Request capture; write wins when both enables are high.
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            a_q  <= addr;
            d_q  <= data_in;
            be_q <= byte_en;
            wr_q <= write_enable;
        end
    end

endmodule

// File: tb/tb_ru_ram_ws.sv
// Randomised self-checking bench for ru_ram_ws against a word-array model.
// Directed cases cover latency, byte lanes, errors and mid-access reset.
module tb_ru_ram_ws;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic          clk = 1'b0;
    logic          nRst;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic [3:0]    byte_en;
    logic          read_enable;
    logic          write_enable;
    logic [DW-1:0] data_out;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    ru_ram_ws #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEPTH),
        .LATENCY(LAT)
    ) dut (
        .clk         (clk),
        .nRst        (nRst),
        .addr        (addr),
        .data_in     (data_in),
        .byte_en     (byte_en),
        .read_enable (read_enable),
        .write_enable(write_enable),
        .data_out    (data_out),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    logic [31:0] mem_m [DEPTH];
    logic [31:0] last_q;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        read_enable  = 1'b0;
        write_enable = 1'b0;
        addr         = '0;
        data_in      = '0;
        byte_en      = '0;
    endtask

    task automatic access(input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, output logic [31:0] q);
        bit          bad;
        int          cyc;
        logic [31:0] exp_q;
        logic [31:0] m;
        bad   = (a % 4 != 0) || (a >= DEPTH * 4);
        exp_q = last_q;
        if (wr) begin
            if (!bad) begin
                m = mem_m[a / 4];
                for (int i = 0; i < 4; i++)
                    if (be[i]) m[8*i +: 8] = d[8*i +: 8];
                mem_m[a / 4] = m;
            end
        end else begin
            exp_q = bad ? 32'h0 : mem_m[a / 4];
        end

        @(posedge clk); #1;
        read_enable  = rd;
        write_enable = wr;
        addr         = a;
        data_in      = d;
        byte_en      = be;
        cyc = 0;
        @(negedge clk);
        check("busy_req", busy, 1);
        check("done_req", done, 0);
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            // stalled core inputs wander; DUT must use the latched request
            read_enable  = 1'($urandom);
            write_enable = 1'($urandom);
            addr         = $urandom;
            data_in      = $urandom;
            byte_en      = 4'($urandom);
            cyc++;
            @(negedge clk);
            if (!done) check("busy_wait", busy, 1);
        end
        check("latency", 32'(cyc), 32'(LAT + 1));
        check("busy_done", busy, 0);
        check("err_done", err, 32'(bad));
        check("dout_done", data_out, exp_q);
        q = data_out;
        last_q = exp_q;

        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_err", err, 0);
        check("dout_hold", data_out, exp_q);
    endtask

    task automatic rand_access();
        int          sel;
        int          op;
        logic [31:0] a;
        logic [31:0] q;
        sel = $urandom_range(0, 9);
        op  = $urandom_range(0, 2);
        if (sel == 0)
            a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        else if (sel == 1)
            a = $urandom_range(1024, 8191);
        else
            a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        access(op != 1, op != 0, a, $urandom, 4'($urandom), q);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q;
        idle_inputs();
        nRst   = 1'b0;
        last_q = '0;

        write_enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_dout", data_out, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(posedge clk); #1;
        write_enable = 1'b0;
        nRst = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done2", done, 0);

        for (int i = 0; i < DEPTH; i++)
            access(1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF, q);

        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, q);
        access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, q);
        check("rd_deadbeef", q, 32'hDEADBEEF);

        access(1'b0, 1'b1, 32'h20, 32'hAAAAAAAA, 4'hF, q);
        access(1'b0, 1'b1, 32'h20, 32'h11223344, 4'b0101, q);
        access(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, q);
        check("lane_merge", q, 32'hAA22AA44);

        access(1'b1, 1'b0, 32'h13, 32'h0, 4'hF, q);
        check("misalign_rd", q, 32'h0);
        access(1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, q);
        access(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, q);
        access(1'b1, 1'b0, 32'h404, 32'h0, 4'h0, q);
        check("oor_rd", q, 32'h0);
        access(1'b0, 1'b1, 32'h50, 32'hFFFFFFFF, 4'h0, q);
        access(1'b1, 1'b0, 32'h50, 32'h0, 4'h0, q);

        @(posedge clk); #1;
        write_enable = 1'b1;
        addr         = 32'h30;
        data_in      = 32'h55;
        byte_en      = 4'hF;
        @(posedge clk); #1;
        nRst = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        nRst   = 1'b1;
        last_q = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_nodone", done, 0);
            check("abort_busy", busy, 0);
        end
        access(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, q);

        access(1'b1, 1'b0, 32'h44, 32'h0, 4'h0, q);
        access(1'b1, 1'b1, 32'h40, 32'h12345678, 4'hF, q);
        check("both_hold", q, mem_m[32'h44 / 4]);
        access(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, q);
        check("both_wr", q, 32'h12345678);

        for (int i = 0; i < 300; i++) rand_access();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
